me_block_scheduler: RTL
=======================

Name: me_block_scheduler

Overview:
Frame-level sequencer for the motion-estimation PE row. It walks current-frame blocks in raster order and launches one PE-row search per block. While a search runs it drives the pixel-stream enable and cycle index used by the pixel fetch logic. On completion it captures the best motion vector and hands it out on a valid/ready result port.

Parameters:
BLK_SIZE, 8, block edge in pixels; must equal the PE-row block size.
FRAME_W_BLKS, 4, blocks per frame row (1..255).
FRAME_H_BLKS, 4, block rows per frame (1..255).
TIMEOUT_CYCLES, 8192, watchdog limit per search; used only with ME_SCHED_TIMEOUT_EN.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
frame_start  in  1  one-cycle request to process a full frame.
frame_busy  out  1  high from acceptance of frame_start until the frame_done cycle, inclusive.
frame_done  out  1  one-cycle pulse after the last block's result is accepted.
row_start  out  1  one-cycle start pulse to the PE row.
row_done  in  1  PE-row completion pulse.
row_m_i  in  8  best candidate row offset from the PE row.
row_m_j  in  8  best candidate column offset from the PE row.
pix_en  out  1  pixel streams (c, p, p_prime) are to be presented this cycle.
pix_cycle  out  12  stream cycle index, 0-based, within the current search.
blk_x  out  8  current block column.
blk_y  out  8  current block row.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_blk_x  out  8  block column of the result.
res_blk_y  out  8  block row of the result.
res_mv_i  out  8  captured row offset.
res_mv_j  out  8  captured column offset.
res_timeout  out  1  result was produced by a watchdog expiry.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on reset.
- Reset values: every output is 0 and the FSM is in IDLE. Reset mid-frame aborts the frame with no frame_done. The PE row shares the same reset.
- FSM states: IDLE, LAUNCH, RUN, RESULT, NEXT, DONE.
- IDLE: frame_start=1 clears blk_x and blk_y to 0 and moves to LAUNCH. frame_busy rises in the following cycle.
- LAUNCH: row_start=1 for exactly one cycle, pix_cycle is cleared to 0, and the FSM moves to RUN.
- RUN:
  - pix_en=1; pix_cycle increments every cycle and saturates at 4095.
  - On row_done=1, row_m_i and row_m_j are captured into res_mv_i and res_mv_j, res_blk_x/res_blk_y take blk_x/blk_y, res_timeout=0, and the FSM moves to RESULT.
  - pix_en falls in the same cycle res_valid rises, i.e. the cycle after row_done.
- RESULT: res_valid=1 and all res_* fields are held stable until res_ready=1. On the handshake (valid and ready both high) the FSM moves to NEXT, and res_valid is 0 in the next cycle.
- NEXT:
  - If blk_x < FRAME_W_BLKS-1: blk_x increments, then LAUNCH.
  - Otherwise blk_x goes to 0. If blk_y < FRAME_H_BLKS-1: blk_y increments, then LAUNCH.
  - Otherwise go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE. frame_busy is low the cycle after DONE.
- Latency:
  - frame_start to row_start is 1 cycle.
  - Handshake to the next row_start is 2 cycles (NEXT, then LAUNCH).
  - row_done to res_valid is 1 cycle.
- Boundary conditions:
  - frame_start outside IDLE is ignored and not queued.
  - row_done outside RUN is ignored.
  - row_done in the same cycle as LAUNCH is ignored.
  - res_ready without res_valid has no effect.
  - With FRAME_W_BLKS=FRAME_H_BLKS=1 the frame is exactly one search.
  - blk_x and blk_y never exceed FRAME_*_BLKS-1.
- Arithmetic: all counters are unsigned. The m_i/m_j values are passed through unmodified at 8 bits.

Optional Feature:
ME_SCHED_TIMEOUT_EN
- Defined:
  - A watchdog counter clears in LAUNCH and increments in RUN.
  - When it reaches TIMEOUT_CYCLES-1 without row_done, the FSM moves to RESULT with res_mv_i=res_mv_j=0 and res_timeout=1; the frame then continues normally.
  - If row_done coincides with expiry, row_done wins and res_timeout=0.
- Undefined: RUN waits indefinitely for row_done, res_timeout is tied to 0, and no watchdog logic is instantiated.

Decomposition:
- Shared package me_pkg holds:
  - the FSM state typedef;
  - BLK_SIZE, MV_W=8, BLK_IDX_W=8, PIX_CYCLE_W=12.
- BLK_SIZE is sourced from the common parameters so it stays consistent with the PE row.
- Natural sub-module: me_sched_wdog, the watchdog counter with clear, enable and expire outputs, instantiated only under ME_SCHED_TIMEOUT_EN.

Test Plan:
- 2x2 frame, row_done 50 cycles after each row_start, res_ready held 1:
  - four results in order (0,0), (1,0), (0,1), (1,1) carrying the driven m_i/m_j;
  - frame_done pulses once;
  - exactly four row_start pulses.
- res_ready low for 10 cycles in RESULT → res_* stable throughout, no new row_start; the next row_start comes 2 cycles after the handshake.
- frame_start pulsed during RUN → ignored; frame completes with the correct count; a later frame_start in IDLE starts a fresh frame at (0,0).
- reset asserted in RUN of block (1,0) → all outputs 0 next cycle and no frame_done; a new frame_start restarts at (0,0).
- ME_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=16 and row_done never driven → result with res_timeout=1 and mv=0 at 16 cycles after LAUNCH.
- ME_SCHED_TIMEOUT_EN with TIMEOUT_CYCLES=16, row_done at the expiry cycle → res_timeout=0 and mv captured.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: shared types and constants for the motion-estimation block scheduler.
// BLK_SIZE is the common block edge shared with the PE row, so both stay in step.
package me_pkg;

  localparam int BLK_SIZE    = 8;
  localparam int MV_W        = 8;
  localparam int BLK_IDX_W   = 8;
  localparam int PIX_CYCLE_W = 12;

  // Stream cycle index stops here rather than wrapping.
  localparam logic [PIX_CYCLE_W-1:0] PIX_CYCLE_MAX = '1;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RESULT,
    S_NEXT,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/me_sched_wdog.sv
// me_sched_wdog: per-search watchdog for me_block_scheduler.
// Only instantiated when ME_SCHED_TIMEOUT_EN is defined.
// clear restarts the count, enable advances it, and expire flags the
// enabled cycle in which the count steps onto TIMEOUT_CYCLES-1.
module me_sched_wdog #(
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = count_q + CNT_W'(1);
  assign expire    = enable && !clear && (count_inc == LIMIT);

  // Next count: clear wins, otherwise count up while enabled and below the limit.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LIMIT)) begin
      count_d = count_inc;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/me_block_scheduler.sv
// me_block_scheduler: frame-level raster sequencer for the ME PE row.
// Walks blocks in raster order, launches one PE-row search per block, drives
// the pixel-stream enable/index during the search and returns the best motion
// vector on a valid/ready result port.
// Optional: define ME_SCHED_TIMEOUT_EN to add a per-search watchdog; without it
// RUN waits indefinitely for row_done and res_timeout is tied low.
module me_block_scheduler
  import me_pkg::*;
#(
  parameter int FRAME_W_BLKS   = 4,
  parameter int FRAME_H_BLKS   = 4,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   row_start,
  input  logic                   row_done,
  input  logic [MV_W-1:0]        row_m_i,
  input  logic [MV_W-1:0]        row_m_j,
  output logic                   pix_en,
  output logic [PIX_CYCLE_W-1:0] pix_cycle,
  output logic [BLK_IDX_W-1:0]   blk_x,
  output logic [BLK_IDX_W-1:0]   blk_y,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [BLK_IDX_W-1:0]   res_blk_x,
  output logic [BLK_IDX_W-1:0]   res_blk_y,
  output logic [MV_W-1:0]        res_mv_i,
  output logic [MV_W-1:0]        res_mv_j,
  output logic                   res_timeout
);

  // Reject frame geometries the 8-bit block indices cannot represent.
  if (FRAME_W_BLKS < 1 || FRAME_W_BLKS > 255 || FRAME_H_BLKS < 1 || FRAME_H_BLKS > 255 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("me_block_scheduler: frame size or timeout out of range");
  end

  localparam logic [BLK_IDX_W-1:0] LAST_X = BLK_IDX_W'(FRAME_W_BLKS - 1);
  localparam logic [BLK_IDX_W-1:0] LAST_Y = BLK_IDX_W'(FRAME_H_BLKS - 1);

  sched_state_e             state_q,     state_d;
  logic [BLK_IDX_W-1:0]     blk_x_q,     blk_x_d;
  logic [BLK_IDX_W-1:0]     blk_y_q,     blk_y_d;
  logic [PIX_CYCLE_W-1:0]   pix_cycle_q, pix_cycle_d;
  logic [BLK_IDX_W-1:0]     res_blk_x_q, res_blk_x_d;
  logic [BLK_IDX_W-1:0]     res_blk_y_q, res_blk_y_d;
  logic [MV_W-1:0]          res_mv_i_q,  res_mv_i_d;
  logic [MV_W-1:0]          res_mv_j_q,  res_mv_j_d;

`ifdef ME_SCHED_TIMEOUT_EN
  logic res_timeout_q, res_timeout_d;
  logic wdog_expire;

  me_sched_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == S_LAUNCH),
    .enable (state_q == S_RUN),
    .expire (wdog_expire)
  );

  assign res_timeout = res_timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

  // Control outputs decode straight from the state, so reset forces them low.
  assign frame_busy = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign row_start  = (state_q == S_LAUNCH);
  assign pix_en     = (state_q == S_RUN);
  assign res_valid  = (state_q == S_RESULT);

  assign pix_cycle = pix_cycle_q;
  assign blk_x     = blk_x_q;
  assign blk_y     = blk_y_q;
  assign res_blk_x = res_blk_x_q;
  assign res_blk_y = res_blk_y_q;
  assign res_mv_i  = res_mv_i_q;
  assign res_mv_j  = res_mv_j_q;

  // Next-state, block walk, stream index and result capture.
  always_comb begin
    state_d     = state_q;
    blk_x_d     = blk_x_q;
    blk_y_d     = blk_y_q;
    pix_cycle_d = pix_cycle_q;
    res_blk_x_d = res_blk_x_q;
    res_blk_y_d = res_blk_y_q;
    res_mv_i_d  = res_mv_i_q;
    res_mv_j_d  = res_mv_j_q;
`ifdef ME_SCHED_TIMEOUT_EN
    res_timeout_d = res_timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // frame_start elsewhere is simply not looked at, so it is never queued.
        if (frame_start) begin
          blk_x_d = '0;
          blk_y_d = '0;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        // row_done here belongs to no search and is ignored.
        pix_cycle_d = '0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        if (pix_cycle_q != PIX_CYCLE_MAX) begin
          pix_cycle_d = pix_cycle_q + PIX_CYCLE_W'(1);
        end
        // A real completion beats a simultaneous watchdog expiry.
        if (row_done) begin
          res_mv_i_d  = row_m_i;
          res_mv_j_d  = row_m_j;
          res_blk_x_d = blk_x_q;
          res_blk_y_d = blk_y_q;
`ifdef ME_SCHED_TIMEOUT_EN
          res_timeout_d = 1'b0;
`endif
          state_d     = S_RESULT;
        end
`ifdef ME_SCHED_TIMEOUT_EN
        else if (wdog_expire) begin
          res_mv_i_d    = '0;
          res_mv_j_d    = '0;
          res_blk_x_d   = blk_x_q;
          res_blk_y_d   = blk_y_q;
          res_timeout_d = 1'b1;
          state_d       = S_RESULT;
        end
`endif
      end

      S_RESULT: begin
        // res_valid is implied by the state, so ready alone is the handshake.
        if (res_ready) begin
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        if (blk_x_q < LAST_X) begin
          blk_x_d = blk_x_q + BLK_IDX_W'(1);
          state_d = S_LAUNCH;
        end else begin
          blk_x_d = '0;
          if (blk_y_q < LAST_Y) begin
            blk_y_d = blk_y_q + BLK_IDX_W'(1);
            state_d = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to zero in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      blk_x_q     <= '0;
      blk_y_q     <= '0;
      pix_cycle_q <= '0;
      res_blk_x_q <= '0;
      res_blk_y_q <= '0;
      res_mv_i_q  <= '0;
      res_mv_j_q  <= '0;
`ifdef ME_SCHED_TIMEOUT_EN
      res_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      blk_x_q     <= blk_x_d;
      blk_y_q     <= blk_y_d;
      pix_cycle_q <= pix_cycle_d;
      res_blk_x_q <= res_blk_x_d;
      res_blk_y_q <= res_blk_y_d;
      res_mv_i_q  <= res_mv_i_d;
      res_mv_j_q  <= res_mv_j_d;
`ifdef ME_SCHED_TIMEOUT_EN
      res_timeout_q <= res_timeout_d;
`endif
    end
  end

endmodule
